// File: rtl/alu4_seq_ctrl_if.sv
// Command and response handshake bundle between a command source
// (host or microcode) and the alu4 sequencer.
interface alu4_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;

  // Command source side: issues commands, consumes responses.
  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
  );

  // Sequencer side: accepts commands, produces responses.
  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu4_seq_ctrl.sv
// Sequencing front end for one combinational alu4 instance.
// Commands {load, op, data} are queued in a small FIFO, issued one at a
// time to the ALU through registered operand/select outputs, and each
// result is returned on a held valid/ready response port in command order.
module alu4_seq_ctrl #(
  parameter int         DEPTH    = 4,
  parameter logic [3:0] ACC_INIT = 4'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu4_seq_ctrl_if.slave        bus,
  output logic [3:0]            alu_a,
  output logic [3:0]            alu_b,
  output logic [2:0]            alu_sel,
  input  logic [3:0]            alu_out,
  input  logic                  alu_carry,
  output logic [3:0]            acc,
  output logic                  busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic [7:0]  fifo_mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [7:0]  head;
  logic        load_q;
  logic        rsp_valid_q;
  logic [3:0]  rsp_data_q;
  logic        rsp_carry_q;
  logic        rsp_zero_q;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Full blocks a push even when a pop happens in the same cycle.
  assign push = bus.cmd_valid && !full;
  assign pop  = (state == IDLE) && !empty;
  assign head = fifo_mem[rd_ptr[AW-1:0]];

  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign busy          = (state != IDLE) || !empty;

  // FIFO storage: payload only, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {bus.cmd_load, bus.cmd_op, bus.cmd_data};
    end
  end

  // Write pointer advances on every accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Issue/execute/respond sequencer; also owns the read pointer and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      load_q      <= 1'b0;
      acc         <= ACC_INIT;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            rd_ptr  <= rd_ptr + {{AW{1'b0}}, 1'b1};
            alu_a   <= acc;
            alu_b   <= head[3:0];
            alu_sel <= head[6:4];
            load_q  <= head[7];
            state   <= EXEC;
          end
        end
        EXEC: begin
          // Loads bypass the ALU; compare reports without touching acc.
          if (load_q) begin
            rsp_data_q  <= alu_b;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= (alu_b == 4'h0);
            acc         <= alu_b;
          end else if (alu_sel == OP_CMP) begin
            rsp_data_q  <= alu_out;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= (alu_out == 4'h0);
          end else begin
            rsp_data_q  <= alu_out;
            rsp_carry_q <= alu_carry;
            rsp_zero_q  <= (alu_out == 4'h0);
            acc         <= alu_out;
          end
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Directed bench for alu4_seq_ctrl with a behavioural alu4 model attached
// to the ALU-side ports.
module tb_alu4_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_out;
  logic       alu_carry;
  logic [3:0] acc;
  logic       busy;
  logic [4:0] alu_t;

  int checks = 0;
  int errors = 0;

  alu4_seq_ctrl_if bus ();

  alu4_seq_ctrl #(.DEPTH(4), .ACC_INIT(4'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .acc       (acc),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // alu4 model: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 CMP.
  // Compare drives a nonzero carry when A>=B so the sequencer's masking shows.
  always_comb begin
    alu_t = 5'd0;
    case (alu_sel)
      3'b000: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: alu_t = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010: alu_t = {1'b0, alu_a & alu_b};
      3'b011: alu_t = {1'b0, alu_a | alu_b};
      3'b100: alu_t = {1'b0, alu_a ^ alu_b};
      3'b101: alu_t = {alu_a[3], alu_a[2:0], 1'b0};
      3'b110: alu_t = {alu_a[0], 1'b0, alu_a[3:1]};
      default: alu_t = {(alu_a >= alu_b), 3'b000, (alu_a == alu_b)};
    endcase
    alu_out   = alu_t[3:0];
    alu_carry = alu_t[4];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic ld, input logic [2:0] op, input logic [3:0] d);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.cmd_ready) begin
      errors++;
      $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
    end else begin
      tick();
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic got, output logic [3:0] d, output logic c,
                         output logic z, output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    got = bus.rsp_valid;
    d   = bus.rsp_data;
    c   = bus.rsp_carry;
    z   = bus.rsp_zero;
    if (got && bus.rsp_ready) tick();
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_data  = 4'h0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_zero, busy} !== 9'b1_0_0000_0_0_0) begin
      errors++;
      $display("FAIL reset_handshake: ready/valid/data/c/z/busy=%b, required 100000000",
               {bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_zero, busy});
    end
    checks++;
    if ({alu_a, alu_b, alu_sel, acc} !== 15'h0) begin
      errors++;
      $display("FAIL reset_regs: alu_a=%h alu_b=%h alu_sel=%h acc=%h, required all 0", alu_a, alu_b, alu_sel, acc);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_add();
    logic got, c, z;
    logic [3:0] d;
    int lat;
    push(1'b1, 3'b000, 4'hF);
    get_rsp(got, d, c, z, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL load_latency: %0d cycles, required 2", lat);
    end
    checks++;
    if ({got, d, c, z} !== {1'b1, 4'hF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_F: got=%b data=%h c=%b z=%b, required 1 F 0 0", got, d, c, z);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_drop: rsp_valid=%b after accept, required 0", bus.rsp_valid);
    end
    push(1'b0, 3'b000, 4'h1);
    get_rsp(got, d, c, z, lat);
    checks++;
    if ({got, d, c, z, lat} !== {1'b1, 4'h0, 1'b1, 1'b1, 32'd2}) begin
      errors++;
      $display("FAIL add_wrap: got=%b data=%h c=%b z=%b lat=%0d, required 1 0 1 1 2", got, d, c, z, lat);
    end
    checks++;
    if (acc !== 4'h0) begin
      errors++;
      $display("FAIL add_acc: acc=%h, required 0", acc);
    end
  endtask

  task automatic test_sub_shl();
    logic got, c, z;
    logic [3:0] d;
    int lat;
    push(1'b1, 3'b000, 4'h3);
    get_rsp(got, d, c, z, lat);
    checks++;
    if ({got, d, c, z} !== {1'b1, 4'h3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_3: got=%b data=%h c=%b z=%b, required 1 3 0 0", got, d, c, z);
    end
    push(1'b0, 3'b001, 4'h5);
    get_rsp(got, d, c, z, lat);
    checks++;
    if ({got, d, c, z} !== {1'b1, 4'hE, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow: got=%b data=%h c=%b z=%b, required 1 E 1 0", got, d, c, z);
    end
    push(1'b0, 3'b101, 4'h6);
    get_rsp(got, d, c, z, lat);
    checks++;
    if ({got, d, c, z} !== {1'b1, 4'hC, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL shl: got=%b data=%h c=%b z=%b, required 1 C 1 0", got, d, c, z);
    end
    checks++;
    if ({acc, alu_a, alu_b, alu_sel} !== {4'hC, 4'hE, 4'h6, 3'b101}) begin
      errors++;
      $display("FAIL shl_regs: acc=%h alu_a=%h alu_b=%h alu_sel=%b, required C E 6 101", acc, alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_cmp();
    logic got, c, z;
    logic [3:0] d;
    int lat;
    push(1'b1, 3'b000, 4'h7);
    get_rsp(got, d, c, z, lat);
    checks++;
    if ({got, d, c, z} !== {1'b1, 4'h7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_7: got=%b data=%h c=%b z=%b, required 1 7 0 0", got, d, c, z);
    end
    push(1'b0, 3'b111, 4'h7);
    get_rsp(got, d, c, z, lat);
    checks++;
    if ({got, d, c, z} !== {1'b1, 4'h1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL cmp_eq: got=%b data=%h c=%b z=%b, required 1 1 0 0", got, d, c, z);
    end
    checks++;
    if (acc !== 4'h7) begin
      errors++;
      $display("FAIL cmp_acc: acc=%h, required 7", acc);
    end
    push(1'b0, 3'b000, 4'h0);
    get_rsp(got, d, c, z, lat);
    checks++;
    if ({got, d, c, z} !== {1'b1, 4'h7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_0: got=%b data=%h c=%b z=%b, required 1 7 0 0", got, d, c, z);
    end
  endtask

  task automatic test_back_to_back();
    logic got, c, z;
    logic [3:0] d;
    int lat;
    logic [2:0] ops  [5] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic       lds  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] dats [5] = '{4'h1, 4'h1, 4'h1, 4'h2, 4'hF};
    logic [3:0] exp_d[5] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h4};
    logic       exp_c[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(lds[i], ops[i], dats[i]);
    // Offer a sixth command while the FIFO is full; it must not be taken.
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b1;
    bus.cmd_op    = 3'b000;
    bus.cmd_data  = 4'hA;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_ready: cmd_ready=%b cycle %0d, required 0", bus.cmd_ready, i);
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, busy} !== {1'b1, 4'h1, 1'b1}) begin
      errors++;
      $display("FAIL stall_head: valid=%b data=%h busy=%b, required 1 1 1", bus.rsp_valid, bus.rsp_data, busy);
    end
    repeat (3) tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_zero} !== {1'b1, 4'h1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stall_stable: valid=%b data=%h c=%b z=%b, required 1 1 0 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_zero);
    end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_rsp(got, d, c, z, lat);
      checks++;
      if ({got, d, c, z} !== {1'b1, exp_d[i], exp_c[i], 1'b0}) begin
        errors++;
        $display("FAIL drain_%0d: got=%b data=%h c=%b z=%b, required 1 %h %b 0", i, got, d, c, z, exp_d[i], exp_c[i]);
      end
    end
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid) got = 1'b1;
      tick();
    end
    checks++;
    if ({got, busy, bus.cmd_ready, acc} !== {1'b0, 1'b0, 1'b1, 4'h4}) begin
      errors++;
      $display("FAIL drain_end: extra_rsp=%b busy=%b cmd_ready=%b acc=%h, required 0 0 1 4", got, busy, bus.cmd_ready, acc);
    end
  endtask

  task automatic test_reset_mid();
    logic got, c, z, seen;
    logic [3:0] d;
    int lat;
    push(1'b1, 3'b000, 4'h9);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready, busy, acc, alu_a, alu_b, alu_sel} !== {1'b0, 1'b1, 1'b0, 15'h0}) begin
      errors++;
      $display("FAIL async_reset: valid=%b ready=%b busy=%b acc=%h alu_a=%h alu_b=%h alu_sel=%b, required 0 1 0 0 0 0 0",
               bus.rsp_valid, bus.cmd_ready, busy, acc, alu_a, alu_b, alu_sel);
    end
    repeat (2) tick();
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.rsp_valid || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: response or busy seen=%b, required 0", seen);
    end
    push(1'b1, 3'b000, 4'h2);
    get_rsp(got, d, c, z, lat);
    checks++;
    if ({got, d, c, z, acc} !== {1'b1, 4'h2, 1'b0, 1'b0, 4'h2}) begin
      errors++;
      $display("FAIL post_reset_load: got=%b data=%h c=%b z=%b acc=%h, required 1 2 0 0 2", got, d, c, z, acc);
    end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_sub_shl();
    test_cmp();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
